// File: rtl/lut_sign_restore_module_pkg.sv
// Shared widths and defaults for the LUT multiplier
// sign-restore stage.
package lut_sign_restore_module_pkg;

  localparam int OP_W      = 9;
  localparam int MAG_W     = 17;
  localparam int RES_W     = 18;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/lut_sign_restore_module_sign_fifo.sv
// In-order 1-bit sign queue with occupancy tracking
// and sticky overflow/underflow detection.
module sign_fifo_module
  import lut_sign_restore_module_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        push_data,
  input  logic        pop,
  output logic        pop_data,
  output logic [AW:0] level,
  output logic        empty,
  output logic        full,
  output logic        err_overflow,
  output logic        err_underflow
);

  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (level == '0);
  assign full  = (level == FULL);

  // A full queue still accepts a push when the same
  // cycle pops, since the pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);

  // An empty queue reads as sign 0 (no bypass).
  assign pop_data = empty ? 1'b0 : mem[rd_ptr];

  // Sign storage; contents are don't-care at reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
      if (push & full & ~pop) err_overflow  <= 1'b1;
      if (pop & empty)        err_underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/lut_sign_restore_module.sv
// Re-applies queued operand signs to unsigned LUT
// products and registers the signed result.
module lut_sign_restore_module
  import lut_sign_restore_module_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [OP_W-1:0]  i1_in,
  input  logic [OP_W-1:0]  i2_in,
  input  logic             prod_valid,
  input  logic [MAG_W-1:0] prod_in,
  output logic [RES_W-1:0] result_out,
  output logic             result_valid,
  output logic [AW:0]      level_out,
  output logic             err_overflow,
  output logic             err_underflow
);

  logic             sign_in;
  logic             sign_pop;
  logic             q_empty;
  logic             q_full;
  logic [RES_W-1:0] ext;
  logic [RES_W-1:0] neg;
  logic             unused_bits;

  assign sign_in     = i1_in[OP_W-1] ^ i2_in[OP_W-1];
  assign unused_bits = ^{i1_in[OP_W-2:0], i2_in[OP_W-2:0],
                         q_empty, q_full};

  sign_fifo_module #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (op_valid),
    .push_data    (sign_in),
    .pop          (prod_valid),
    .pop_data     (sign_pop),
    .level        (level_out),
    .empty        (q_empty),
    .full         (q_full),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  assign ext = {1'b0, prod_in};
  assign neg = ~ext + RES_W'(1);

  // Output register: negate when the popped sign is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= prod_valid;
      if (prod_valid) result_out <= sign_pop ? neg : ext;
    end
  end

endmodule

// File: tb/tb_lut_sign_restore_module.sv
// Self-checking bench for lut_sign_restore_module
// against a queue-based reference model.
module tb_lut_sign_restore_module;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [8:0]  i1_in = '0;
  logic [8:0]  i2_in = '0;
  logic        prod_valid = 1'b0;
  logic [16:0] prod_in = '0;
  logic [17:0] result_out;
  logic        result_valid;
  logic [2:0]  level_out;
  logic        err_overflow;
  logic        err_underflow;

  int total = 0;
  int bad   = 0;

  bit          mq[$];
  bit          m_ovf;
  bit          m_unf;
  logic [17:0] m_res;
  bit          m_rv;

  lut_sign_restore_module #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .i1_in        (i1_in),
    .i2_in        (i2_in),
    .prod_valid   (prod_valid),
    .prod_in      (prod_in),
    .result_out   (result_out),
    .result_valid (result_valid),
    .level_out    (level_out),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".rv"}, 32'(result_valid), 32'(m_rv));
    chk({tag, ".res"}, 32'(result_out), 32'(m_res));
    chk({tag, ".lvl"}, 32'(level_out), mq.size());
    chk({tag, ".ovf"}, 32'(err_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(err_underflow), 32'(m_unf));
  endtask

  // One clock: drive, clock, update model, compare.
  task automatic step(string tag, bit ov, logic [8:0] a,
                      logic [8:0] b, bit pv,
                      logic [16:0] p);
    int pre;
    bit s;
    op_valid   = ov;
    i1_in      = a;
    i2_in      = b;
    prod_valid = pv;
    prod_in    = p;
    @(posedge clk);
    #1;
    pre  = mq.size();
    m_rv = pv;
    if (pv) begin
      s = 1'b0;
      if (pre == 0) m_unf = 1'b1;
      else s = mq.pop_front();
      m_res = s ? 18'(-int'(p)) : 18'(p);
    end
    if (ov) begin
      if (pre == DEPTH && !pv) m_ovf = 1'b1;
      else mq.push_back(a[8] ^ b[8]);
    end
    op_valid   = 1'b0;
    prod_valid = 1'b0;
    chk_all(tag);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step("idle", 0, '0, '0, 0, '0);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #2;
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    m_res = '0;
    m_rv  = 0;
    chk_all(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset("reset");

    step("tp1.op", 1, 9'h1FD, 9'd5, 0, '0);
    chk("tp1.lvl1", 32'(level_out), 1);
    idle(2);
    step("tp1.prod", 0, '0, '0, 1, 17'd15);
    chk("tp1.val", 32'(result_out), 32'h3FFF1);
    step("tp1.after", 0, '0, '0, 0, '0);
    chk("tp1.pulse", 32'(result_valid), 0);

    step("ext.op0", 1, 9'h100, 9'h100, 0, '0);
    step("ext.op1", 1, 9'h100, 9'h0FF, 0, '0);
    step("ext.op2", 1, 9'h000, 9'h1F9, 0, '0);
    chk("ext.peak", 32'(level_out), 3);
    step("ext.p0", 0, '0, '0, 1, 17'd65536);
    chk("ext.r0", 32'(result_out), 32'h10000);
    step("ext.p1", 0, '0, '0, 1, 17'd65280);
    chk("ext.r1", 32'(result_out), 32'h30100);
    step("ext.p2", 0, '0, '0, 1, 17'd0);
    chk("ext.r2", 32'(result_out), 0);

    for (int k = 0; k < 12; k++) begin
      logic [8:0] a;
      a = (k % 2) ? 9'h1F0 : 9'h010;
      step("wrap", k < 10, a, 9'd3, k >= 2,
           17'($urandom_range(65536)));
      chk("wrap.lvlmax", 32'(level_out <= 2), 1);
    end

    for (int k = 0; k < 5; k++)
      step("ovf.op", 1, 9'((k % 2) ? 9'h1FF : 9'h001),
           9'd1, 0, '0);
    chk("ovf.flag", 32'(err_overflow), 1);
    chk("ovf.lvl", 32'(level_out), 4);
    for (int k = 0; k < 4; k++)
      step("ovf.prod", 0, '0, '0, 1, 17'(100 + k));

    do_reset("rst2");
    step("unf.prod", 0, '0, '0, 1, 17'd9);
    chk("unf.res", 32'(result_out), 9);
    chk("unf.flag", 32'(err_underflow), 1);
    step("unf.both", 1, 9'h1FF, 9'd2, 1, 17'd4);
    chk("unf.lvl", 32'(level_out), 1);

    do_reset("rst3");
    for (int k = 0; k < 3; k++)
      step("mid.op", 1, 9'h1FF, 9'd2, 0, '0);
    do_reset("mid.rst");
    step("mid.prod", 0, '0, '0, 1, 17'd7);
    chk("mid.unf", 32'(err_underflow), 1);

    do_reset("rst4");
    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset("rnd.rst");
      step("rnd", $urandom_range(1) == 1,
           9'($urandom), 9'($urandom),
           $urandom_range(2) != 0,
           17'($urandom_range(65536)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lut_sign_restore_module.md
Name: lut_sign_restore_module

Overview:
- Output-side companion to the magnitude-conversion stage of the pipelined LUT multiplier.
- On operand acceptance it captures the result sign, i1_in[8] ^ i2_in[8], into a small in-order sign queue.
- When the unsigned product magnitude returns from the LUT pipeline, it pops the oldest sign, applies it (two's-complement negate if 1), and registers the 18-bit signed product.
- The queue decouples sign handling from the LUT pipeline latency, so any in-order latency ≤ DEPTH in-flight operations is supported.

Parameters:
- DEPTH, 4, sign-queue entries (power of two, ≥2); maximum operations in flight between op_valid and prod_valid.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op_valid  input  1  operands i1_in/i2_in accepted by the multiplier this cycle
- i1_in  input  9  signed operand 1 (only bit 8 used)
- i2_in  input  9  signed operand 2 (only bit 8 used)
- prod_valid  input  1  prod_in valid this cycle
- prod_in  input  17  unsigned product magnitude, 0..65536
- result_out  output  18  signed product, two's complement
- result_valid  output  1  result_out valid, one-cycle pulse per product
- level_out  output  AW+1  current queue occupancy, 0..DEPTH
- err_overflow  output  1  sticky: push attempted while full with no pop
- err_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst_n low): clear pointers and level to 0; result_out=0; result_valid=0; both error flags 0; queue contents don't-care. A reset mid-operation discards all in-flight signs, and the first prod_valid after reset is an underflow.
- Push: op_valid=1 writes sign i1_in[8]^i2_in[8] at the write pointer and advances it (wraps DEPTH-1 -> 0).
- Pop: prod_valid=1 reads the entry at the read pointer and advances it (wraps).
- Latency: result_out and result_valid register 1 cycle after prod_valid. result_valid is high for exactly one cycle per prod_valid, including underflow cases.
- Arithmetic:
  - Zero-extend prod_in to 18 bits.
  - If the popped sign is 1, result = ~ext + 1; otherwise result = ext.
  - Zero magnitude with sign 1 yields 0.
  - Range -65536..+65536 fits in 18-bit signed with no saturation.
- Simultaneous push and pop:
  - Not empty: both performed, level unchanged.
  - Empty: no same-cycle bypass. The pop is an underflow and the push is still performed.
  - Full: the pop frees a slot, both are performed, no overflow.
- Full (level==DEPTH), op_valid=1, prod_valid=0: push dropped, pointers unchanged, err_overflow set.
- Empty (level==0), prod_valid=1:
  - err_underflow set, read pointer not advanced.
  - Sign treated as 0, so result_out = zero-extended prod_in, with result_valid pulsed.
- Error flags stay sticky until reset.
- level_out is registered and reflects state after the current cycle's push/pop.
- i1_in/i2_in are ignored when op_valid=0. prod_in is ignored when prod_valid=0, and result_out holds its last value.

Decomposition:
- Shared package holds: operand width 9, magnitude width 17, result width 18, default DEPTH 4.
- One natural sub-module, sign_fifo_module: a 1-bit-wide, DEPTH-entry synchronous FIFO providing full/empty/level and error detect.
- Top level contains the negate/output register stage.

Test Plan:
- Reset then one op: i1=-3 (9'h1FD), i2=5, op_valid; 3 cycles later prod_in=15, prod_valid -> next cycle result_out=18'h3FFF1 (-15), result_valid=1 for one cycle, level 1->0.
- Extremes: ops (-256,-256), (-256,255), (0,-7) back-to-back; then prod_in 65536, 65280, 0 on consecutive cycles -> results +65536 (18'h10000), -65280 (18'h30100), 0; level peaks at 3.
- Wrap-around and concurrency: 10 ops with alternating signs, prod_valid issued 2 cycles after each op (push and pop overlap) -> all 10 signs correct across pointer wrap, level never exceeds 2, no error flags.
- Overflow: 5 ops with no products (DEPTH=4) -> err_overflow=1 after the 5th, level=4. Then 4 products -> signs match the first 4 ops.
- Underflow: prod_valid with prod_in=9 on empty queue -> result_out=9, result_valid=1, err_underflow=1, level stays 0. Same-cycle op_valid -> level becomes 1.
- Reset mid-flight: 3 ops queued, assert rst_n low for 1 cycle -> level 0, flags 0, result_valid 0. A subsequent product -> err_underflow=1.
